// File: rtl/ps2_host_ctrl_pkg.sv
// Shared PS/2 frame constants, command/response codes, controller states and parity helper.
package ps2_host_ctrl_pkg;

  localparam int FRAME_LEN = 11;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ECHO   = 8'hEE;
  localparam logic [7:0] CMD_LEDS   = 8'hED;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RX           = 3'd1,
    ST_TX_INHIBIT   = 3'd2,
    ST_TX_REQ       = 3'd3,
    ST_TX_BITS      = 3'd4,
    ST_TX_ACK       = 3'd5,
    ST_TX_WAIT_IDLE = 3'd6
  } state_t;

  // Parity bit that makes the data byte plus parity contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous FIFO holding received PS/2 bytes; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign head      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_host_ctrl.sv
// Bidirectional PS/2 host: synchronises and filters the pads, receives device frames
// into a FIFO and sends host commands using the inhibit / request-to-send sequence.
module ps2_host_ctrl
  import ps2_host_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       rx_overflow
);

  localparam int CYC_PER_US  = CLK_HZ / 1_000_000;
  localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
  localparam int FW          = $clog2(FILTER_LEN + 1);

  logic          clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic [FW-1:0] filt_cnt_r;
  logic          filt_clk_r, filt_prev_r, fall_s;
  state_t        state_r, state_next_s;
  logic [31:0]   inh_cnt_r, to_cnt_r;
  logic [3:0]    bit_cnt_r;
  logic [9:0]    rx_shift_r;
  logic [10:0]   rx_frame_s;
  logic [9:0]    tx_shift_r;
  logic          tx_bit_r;
  logic          inh_done_s, timeout_s, rx_last_s, rx_good_s;
  logic          clk_oe_s, data_oe_s, tx_done_s, err_frame_s, push_s, pop_s, overflow_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [7:0]    fifo_head_s;

  // Two-flop synchronisers; the lines idle high
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk_i;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data_i;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN agreeing samples
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      filt_cnt_r  <= '0;
      filt_clk_r  <= 1'b1;
      filt_prev_r <= 1'b1;
    end else begin
      filt_prev_r <= filt_clk_r;
      if (clk_sync_r == filt_clk_r) begin
        filt_cnt_r <= '0;
      end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
        filt_clk_r <= clk_sync_r;
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  assign fall_s     = filt_prev_r && !filt_clk_r;
  assign inh_done_s = (inh_cnt_r == 32'(INHIBIT_CYC - 1));
  assign timeout_s  = !(state_r inside {ST_IDLE, ST_TX_INHIBIT}) && !fall_s &&
                      (to_cnt_r == 32'(TIMEOUT_CYC - 1));
  assign rx_frame_s = {data_sync_r, rx_shift_r};
  assign rx_last_s  = (state_r == ST_RX) && fall_s && (bit_cnt_r == 4'(FRAME_LEN - 1));
  assign rx_good_s  = !rx_frame_s[0] && rx_frame_s[10] && (^rx_frame_s[9:1]);

  // State register
  always_ff @(posedge CLK50MHZ) begin
    if (RST) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // Next-state logic; a receive start beats a simultaneous transmit request
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fall_s)        state_next_s = ST_RX;
        else if (tx_valid) state_next_s = ST_TX_INHIBIT;
        else               state_next_s = ST_IDLE;
      end
      ST_RX: begin
        if (timeout_s || rx_last_s) state_next_s = ST_IDLE;
        else                        state_next_s = ST_RX;
      end
      ST_TX_INHIBIT: begin
        if (inh_done_s) state_next_s = ST_TX_REQ;
        else            state_next_s = ST_TX_INHIBIT;
      end
      ST_TX_REQ: begin
        if (timeout_s) state_next_s = ST_IDLE;
        else           state_next_s = ST_TX_BITS;
      end
      ST_TX_BITS: begin
        if (timeout_s)                             state_next_s = ST_IDLE;
        else if (fall_s && (bit_cnt_r == 4'd9))    state_next_s = ST_TX_ACK;
        else                                       state_next_s = ST_TX_BITS;
      end
      ST_TX_ACK: begin
        if (timeout_s)   state_next_s = ST_IDLE;
        else if (fall_s) state_next_s = data_sync_r ? ST_IDLE : ST_TX_WAIT_IDLE;
        else             state_next_s = ST_TX_ACK;
      end
      ST_TX_WAIT_IDLE: begin
        if (timeout_s || (filt_clk_r && data_sync_r)) state_next_s = ST_IDLE;
        else                                          state_next_s = ST_TX_WAIT_IDLE;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Timers, bit counter and shift registers
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      inh_cnt_r  <= '0;
      to_cnt_r   <= '0;
      bit_cnt_r  <= '0;
      rx_shift_r <= '0;
      tx_shift_r <= '0;
      tx_bit_r   <= 1'b1;
    end else begin
      inh_cnt_r <= (state_r == ST_TX_INHIBIT) ? inh_cnt_r + 32'd1 : 32'd0;
      if ((state_r inside {ST_IDLE, ST_TX_INHIBIT}) || fall_s) to_cnt_r <= '0;
      else                                                     to_cnt_r <= to_cnt_r + 32'd1;
      case (state_r)
        ST_IDLE: begin
          if (fall_s) begin
            rx_shift_r <= {data_sync_r, rx_shift_r[9:1]};
            bit_cnt_r  <= 4'd1;
          end else if (tx_valid) begin
            tx_shift_r <= {1'b1, odd_parity(tx_data), tx_data};
            bit_cnt_r  <= 4'd0;
            tx_bit_r   <= 1'b1;
          end
        end
        ST_RX: begin
          if (fall_s) begin
            rx_shift_r <= {data_sync_r, rx_shift_r[9:1]};
            bit_cnt_r  <= bit_cnt_r + 4'd1;
          end
        end
        ST_TX_REQ: tx_bit_r <= 1'b0;
        ST_TX_BITS: begin
          if (fall_s) begin
            tx_bit_r   <= tx_shift_r[0];
            tx_shift_r <= {1'b1, tx_shift_r[9:1]};
            bit_cnt_r  <= bit_cnt_r + 4'd1;
          end
        end
        default: bit_cnt_r <= bit_cnt_r;
      endcase
    end
  end

  // Output decode from the current state
  always_comb begin
    clk_oe_s    = 1'b0;
    data_oe_s   = 1'b0;
    case (state_r)
      ST_TX_INHIBIT: clk_oe_s = 1'b1;
      ST_TX_REQ: begin
        clk_oe_s  = 1'b1;
        data_oe_s = 1'b1;
      end
      ST_TX_BITS: data_oe_s = ~tx_bit_r;
      default: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
      end
    endcase
    tx_done_s   = (state_r == ST_TX_WAIT_IDLE) && !timeout_s && filt_clk_r && data_sync_r;
    err_frame_s = (rx_last_s && !rx_good_s) ||
                  ((state_r == ST_TX_ACK) && fall_s && data_sync_r);
    push_s      = rx_last_s && rx_good_s;
    pop_s       = rx_ready && !fifo_empty_s;
    overflow_s  = push_s && fifo_full_s && !pop_s;
  end

  // Registered pad enables and status pulses
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      ps2_clk_oe  <= clk_oe_s  && !timeout_s;
      ps2_data_oe <= data_oe_s && !timeout_s;
      tx_done     <= tx_done_s;
      err_frame   <= err_frame_s;
      err_timeout <= timeout_s;
      rx_overflow <= overflow_s;
    end
  end

  ps2_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (CLK50MHZ),
    .rst       (RST),
    .push      (push_s),
    .push_data (rx_frame_s[8:1]),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s)
  );

  assign tx_ready = (state_r == ST_IDLE) && !fall_s;
  assign rx_valid = !fifo_empty_s;
  assign rx_data  = fifo_empty_s ? 8'h00 : fifo_head_s;

endmodule
